// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the cpu_2stage core: machine widths, instruction
// field positions, opcode and ALU function encodings, and immediate
// sign-extension helpers.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN      = 16;
   localparam int REG_COUNT = 8;
   localparam int RIDX_W    = 3;

   // Instruction field positions
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RD_LSB = 9;
   localparam int RA_LSB = 6;
   localparam int RB_LSB = 3;
   localparam int FN_MSB = 2;
   localparam int FN_LSB = 0;

   // Opcodes 8..E are not listed; they decode as NOP.
   typedef enum logic [3:0] {
      OP_ALU  = 4'h0,
      OP_ADDI = 4'h1,
      OP_LI   = 4'h2,
      OP_LD   = 4'h3,
      OP_ST   = 4'h4,
      OP_BZ   = 4'h5,
      OP_BNZ  = 4'h6,
      OP_JAL  = 4'h7,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      FN_ADD  = 3'd0,
      FN_SUB  = 3'd1,
      FN_AND  = 3'd2,
      FN_OR   = 3'd3,
      FN_XOR  = 3'd4,
      FN_SHL  = 3'd5,
      FN_SHR  = 3'd6,
      FN_SLTU = 3'd7
   } alu_fn_e;

   function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
      return {{(XLEN-6){v[5]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
      return {{(XLEN-9){v[8]}}, v};
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_regfile
// 8 x 16-bit general register file; r0 always reads as zero.
// Ports:
//   clk, rst            clock, synchronous active-high clear of all registers
//   i_ra_addr/o_ra_data asynchronous read port A
//   i_rb_addr/o_rb_data asynchronous read port B
//   i_we, i_rd_addr,    synchronous write port; writes to r0 are dropped
//   i_rd_data
// -----------------------------------------------------------------------------
module cpu_regfile
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [RIDX_W-1:0] i_ra_addr,
   output logic [XLEN-1:0]   o_ra_data,
   input  logic [RIDX_W-1:0] i_rb_addr,
   output logic [XLEN-1:0]   o_rb_data,
   input  logic              i_we,
   input  logic [RIDX_W-1:0] i_rd_addr,
   input  logic [XLEN-1:0]   i_rd_data
);

   logic [XLEN-1:0] r_regs [REG_COUNT];

   // NOTE: non-blocking assignments for all clocked state, so every reader
   // sees the pre-edge value regardless of process order. This array is
   // architectural state that must read zero after reset, so it is cleared
   // here; a large data RAM would not get a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_rd_addr != '0)) begin
         r_regs[i_rd_addr] <= i_rd_data;
      end
   end

   assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
   assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];

endmodule

// File: rtl/cpu_2stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_2stage
// 16-bit two-stage (fetch / execute) in-order core, word addressed, with
// separate instruction and data memory ports (both 1-cycle synchronous read).
// Build option: define CPU_HALT_EN to make opcode F halt the core; otherwise
// opcode F is a NOP and halted is tied low.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   iaddr / idata   instruction fetch address (= pc) / word, one cycle later
//   raddr, re       data read address and enable; rdata arrives next cycle
//   rdata           data read value
//   waddr, wdata,   data write address, value, enable (written at next edge)
//   we
//   halted          core is halted (CPU_HALT_EN builds only)
// -----------------------------------------------------------------------------
module cpu_2stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] iaddr,
   input  logic [XLEN-1:0] idata,
   output logic [XLEN-1:0] raddr,
   input  logic [XLEN-1:0] rdata,
   output logic            re,
   output logic [XLEN-1:0] waddr,
   output logic [XLEN-1:0] wdata,
   output logic            we,
   output logic            halted
);

   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_exec_pc;
   logic              r_exec_valid;
   logic              r_ld_pending;
   logic [RIDX_W-1:0] r_ld_rd;

   opcode_e           w_op;
   alu_fn_e           w_fn;
   logic [RIDX_W-1:0] w_rd, w_ra, w_rb, w_rs2_addr;
   logic [XLEN-1:0]   w_simm6, w_simm9;
   logic [XLEN-1:0]   w_ra_val, w_rs2_val, w_alu_res, w_ea, w_br_target;
   logic              w_active;
   logic [XLEN-1:0]   w_next_pc, w_next_exec_pc;
   logic              w_next_valid, w_ld_start;
   logic              w_rf_we;
   logic [RIDX_W-1:0] w_rf_waddr;
   logic [XLEN-1:0]   w_rf_wdata;

`ifdef CPU_HALT_EN
   logic r_halted;
   logic w_halt_now;
`endif

   assign iaddr = r_pc;

   // Decode
   assign w_op    = opcode_e'(idata[OP_MSB:OP_LSB]);
   assign w_fn    = alu_fn_e'(idata[FN_MSB:FN_LSB]);
   assign w_rd    = idata[RD_LSB +: RIDX_W];
   assign w_ra    = idata[RA_LSB +: RIDX_W];
   assign w_rb    = idata[RB_LSB +: RIDX_W];
   assign w_simm6 = sext6(idata[5:0]);
   assign w_simm9 = sext9(idata[8:0]);

   // The second read port serves rb for ALU ops and rd for ST/BZ/BNZ.
   assign w_rs2_addr = (w_op == OP_ALU) ? w_rb : w_rd;

   // Outputs must stay quiet during reset even if a stale valid is latched.
   assign w_active    = r_exec_valid & ~rst;
   assign w_ea        = w_ra_val + w_simm6;
   assign w_br_target = r_exec_pc + 16'd1 + w_simm9;

   cpu_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_ra_addr (w_ra),
      .o_ra_data (w_ra_val),
      .i_rb_addr (w_rs2_addr),
      .o_rb_data (w_rs2_val),
      .i_we      (w_rf_we),
      .i_rd_addr (w_rf_waddr),
      .i_rd_data (w_rf_wdata)
   );

   always_comb begin
      w_alu_res = '0;
      case (w_fn)
         FN_ADD:  w_alu_res = w_ra_val + w_rs2_val;
         FN_SUB:  w_alu_res = w_ra_val - w_rs2_val;
         FN_AND:  w_alu_res = w_ra_val & w_rs2_val;
         FN_OR:   w_alu_res = w_ra_val | w_rs2_val;
         FN_XOR:  w_alu_res = w_ra_val ^ w_rs2_val;
         FN_SHL:  w_alu_res = w_ra_val << w_rs2_val[3:0];
         FN_SHR:  w_alu_res = w_ra_val >> w_rs2_val[3:0];
         FN_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (w_ra_val < w_rs2_val)};
         default: w_alu_res = '0;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      w_next_pc      = r_pc + 16'd1;
      w_next_exec_pc = r_pc;
      w_next_valid   = 1'b1;
      w_ld_start     = 1'b0;
      w_rf_we        = 1'b0;
      w_rf_waddr     = w_rd;
      w_rf_wdata     = '0;
      re             = 1'b0;
      raddr          = '0;
      we             = 1'b0;
      waddr          = '0;
      wdata          = '0;
`ifdef CPU_HALT_EN
      w_halt_now     = 1'b0;
      if (r_halted) begin
         w_next_pc    = r_pc;
         w_next_valid = 1'b0;
      end
`endif

      // Second cycle of a load: the bubble slot returns the data word.
      if (r_ld_pending) begin
         w_rf_we    = 1'b1;
         w_rf_waddr = r_ld_rd;
         w_rf_wdata = rdata;
      end

      if (w_active) begin
         case (w_op)
            OP_ALU: begin
               w_rf_we    = 1'b1;
               w_rf_wdata = w_alu_res;
            end
            OP_ADDI: begin
               w_rf_we    = 1'b1;
               w_rf_wdata = w_ea;
            end
            OP_LI: begin
               w_rf_we    = 1'b1;
               w_rf_wdata = w_simm9;
            end
            OP_LD: begin
               // Hold pc so the word fetched during the bubble is refetched.
               re           = 1'b1;
               raddr        = w_ea;
               w_ld_start   = 1'b1;
               w_next_pc    = r_pc;
               w_next_valid = 1'b0;
            end
            OP_ST: begin
               we    = 1'b1;
               waddr = w_ea;
               wdata = w_rs2_val;
            end
            OP_BZ: begin
               if (w_rs2_val == '0) begin
                  w_next_pc    = w_br_target;
                  w_next_valid = 1'b0;
               end
            end
            OP_BNZ: begin
               if (w_rs2_val != '0) begin
                  w_next_pc    = w_br_target;
                  w_next_valid = 1'b0;
               end
            end
            OP_JAL: begin
               w_rf_we      = 1'b1;
               w_rf_wdata   = r_exec_pc + 16'd1;
               w_next_pc    = w_ra_val;
               w_next_valid = 1'b0;
            end
`ifdef CPU_HALT_EN
            OP_HALT: begin
               w_halt_now   = 1'b1;
               w_next_pc    = r_pc;
               w_next_valid = 1'b0;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_exec_pc    <= RESET_PC;
         r_exec_valid <= 1'b0;
         r_ld_pending <= 1'b0;
         r_ld_rd      <= '0;
      end else begin
         r_pc         <= w_next_pc;
         r_exec_pc    <= w_next_exec_pc;
         r_exec_valid <= w_next_valid;
         r_ld_pending <= w_ld_start;
         if (w_ld_start) begin
            r_ld_rd <= w_rd;
         end
      end
   end

`ifdef CPU_HALT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_halted <= 1'b0;
      end else if (w_halt_now) begin
         r_halted <= 1'b1;
      end
   end
   assign halted = r_halted;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_2stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cpu_2stage
// Instruction-level reference model plus directed and random programs.
// The data-memory event stream (loads and stores, with execute cycle) and a
// register dump stored at addresses 25..31 are compared against the model.
// -----------------------------------------------------------------------------
module tb_cpu_2stage;

   localparam int OP_ALU = 0, OP_ADDI = 1, OP_LI = 2, OP_LD = 3, OP_ST = 4,
                  OP_BZ = 5, OP_BNZ = 6, OP_JAL = 7, OP_NOP = 8, OP_HALT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] iaddr, raddr, waddr, wdata;
   logic [15:0] idata = 16'h0;
   logic [15:0] rdata = 16'h0;
   logic        re, we, halted;

   cpu_2stage #(.RESET_PC(16'h0000)) dut (
      .clk    (clk),
      .rst    (rst),
      .iaddr  (iaddr),
      .idata  (idata),
      .raddr  (raddr),
      .rdata  (rdata),
      .re     (re),
      .waddr  (waddr),
      .wdata  (wdata),
      .we     (we),
      .halted (halted)
   );

   always #5 clk = ~clk;

   logic [15:0] imem   [65536];
   logic [15:0] dmem   [65536];
   logic [15:0] m_dmem [65536];
   logic [15:0] prog   [256];
   int          pl;

   // Memory models: 1-cycle synchronous read, write at the edge.
   always @(posedge clk) begin
      idata <= imem[iaddr];
      if (re === 1'b1) rdata <= dmem[raddr];
      if (we === 1'b1) dmem[waddr] = wdata;
   end

   typedef struct {
      bit          is_st;
      int          cyc;
      logic [15:0] addr;
      logic [15:0] data;
   } ev_t;

   ev_t dut_q[$];
   ev_t exp_q[$];
   int  cyc;
   bit  mon_en = 1'b0;
   int  exp_end;
   bit  exp_halt;

   always @(negedge clk) begin
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
      if (mon_en && !rst) begin
         if (re === 1'b1) dut_q.push_back('{1'b0, cyc, raddr, 16'h0});
         if (we === 1'b1) dut_q.push_back('{1'b1, cyc, waddr, wdata});
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic ev_t dut_ev(input int i);
      ev_t e;
      e = '{1'b0, -1, 16'hxxxx, 16'hxxxx};
      if (i < dut_q.size()) e = dut_q[i];
      return e;
   endfunction

   // ---------------- encoders ----------------
   function automatic logic [15:0] enc_alu(input int fn, input int rd, input int ra, input int rb);
      return 16'((OP_ALU << 12) | (rd << 9) | (ra << 6) | (rb << 3) | fn);
   endfunction
   function automatic logic [15:0] enc_i6(input int op, input int rd, input int ra, input int imm);
      return 16'((op << 12) | (rd << 9) | (ra << 6) | (imm & 63));
   endfunction
   function automatic logic [15:0] enc_i9(input int op, input int rd, input int imm);
      return 16'((op << 12) | (rd << 9) | (imm & 511));
   endfunction

   task automatic emit(input logic [15:0] w);
      prog[pl] = w;
      pl++;
   endtask

   // Store r1..r7 to addresses 25..31, then spin on a taken self-branch.
   task automatic emit_dump();
      for (int r = 1; r < 8; r++) emit(enc_i6(OP_ST, r, 0, 24 + r));
      emit(enc_i9(OP_BZ, 0, -1));
   endtask

   // ---------------- reference model ----------------
   task automatic run_model();
      logic [15:0] r [8];
      logic [15:0] pc, npc, ins, a, b, d, s6, s9, ea, res;
      int          op, fn, rd, ra, rb, c, cost, steps;
      bit          wr, done, taken;
      for (int i = 0; i < 8; i++) r[i] = 16'h0;
      pc = 16'h0000; c = 2; steps = 0; done = 1'b0;
      exp_q.delete();
      exp_halt = 1'b0;
      while (!done && steps < 4000) begin
         ins = imem[pc];
         op = int'(ins[15:12]); rd = int'(ins[11:9]); ra = int'(ins[8:6]);
         rb = int'(ins[5:3]);   fn = int'(ins[2:0]);
         a = r[ra]; b = r[rb]; d = r[rd];
         s6 = {{10{ins[5]}}, ins[5:0]};
         s9 = {{7{ins[8]}}, ins[8:0]};
         npc = pc + 16'd1; cost = 1; wr = 1'b0; res = 16'h0;
         case (op)
            OP_ALU: begin
               wr = 1'b1;
               case (fn)
                  0: res = a + b;
                  1: res = a - b;
                  2: res = a & b;
                  3: res = a | b;
                  4: res = a ^ b;
                  5: res = a << b[3:0];
                  6: res = a >> b[3:0];
                  default: res = (a < b) ? 16'd1 : 16'd0;
               endcase
            end
            OP_ADDI: begin wr = 1'b1; res = a + s6; end
            OP_LI:   begin wr = 1'b1; res = s9; end
            OP_LD: begin
               ea = a + s6;
               exp_q.push_back('{1'b0, c, ea, 16'h0});
               wr = 1'b1; res = m_dmem[ea]; cost = 2;
            end
            OP_ST: begin
               ea = a + s6;
               exp_q.push_back('{1'b1, c, ea, d});
               m_dmem[ea] = d;
            end
            OP_BZ, OP_BNZ: begin
               taken = (op == OP_BZ) ? (d == 16'h0) : (d != 16'h0);
               if (taken) begin
                  npc = pc + 16'd1 + s9; cost = 2;
                  if (npc == pc) done = 1'b1;
               end
            end
            OP_JAL: begin wr = 1'b1; res = pc + 16'd1; npc = a; cost = 2; end
`ifdef CPU_HALT_EN
            OP_HALT: begin exp_halt = 1'b1; done = 1'b1; end
`endif
            default: ;
         endcase
         if (wr && rd != 0) r[rd] = res;
         c += cost;
         pc = npc;
         steps++;
      end
      exp_end = c;
   endtask

   // ---------------- program runner ----------------
   task automatic run_prog(input string name);
      int n;
      @(posedge clk); #1;
      rst = 1'b1;
      mon_en = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         imem[i] = 16'h8000;
         dmem[i] = 16'h0;
         m_dmem[i] = 16'h0;
      end
      for (int i = 0; i < pl; i++) imem[i] = prog[i];
      run_model();
      repeat (2) @(posedge clk);
      #1;
      check({name, ":rst_iaddr"}, iaddr, 16'h0000);
      check({name, ":rst_re"}, {15'b0, re}, 16'h0);
      check({name, ":rst_we"}, {15'b0, we}, 16'h0);
      check({name, ":rst_halted"}, {15'b0, halted}, 16'h0);
      dut_q.delete();
      mon_en = 1'b1;
      rst = 1'b0;
      @(posedge clk); #1;
      check({name, ":iaddr_after_first_edge"}, iaddr, 16'h0001);
      repeat (exp_end + 20) @(posedge clk);
      #1;
      check({name, ":n_events"}, 16'(dut_q.size()), 16'(exp_q.size()));
      n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s:ev%0d_kind", name, i), 16'(dut_q[i].is_st), 16'(exp_q[i].is_st));
         check($sformatf("%s:ev%0d_cyc", name, i), 16'(dut_q[i].cyc), 16'(exp_q[i].cyc));
         check($sformatf("%s:ev%0d_addr", name, i), dut_q[i].addr, exp_q[i].addr);
         check($sformatf("%s:ev%0d_data", name, i), dut_q[i].data, exp_q[i].data);
      end
   endtask

   task automatic gen_random(input int len);
      int k, rd, ra, rb;
      pl = 0;
      for (int i = 0; i < len; i++) begin
         k  = int'($urandom_range(0, 9));
         rd = int'($urandom_range(0, 7));
         ra = int'($urandom_range(0, 7));
         rb = int'($urandom_range(0, 7));
         case (k)
            0, 1, 9: emit(enc_alu(int'($urandom_range(0, 7)), rd, ra, rb));
            2: emit(enc_i6(OP_ADDI, rd, ra, int'($urandom_range(0, 63))));
            3: emit(enc_i9(OP_LI, rd, int'($urandom_range(0, 511))));
            4: emit(enc_i6(OP_LD, rd, ra, int'($urandom_range(0, 63))));
            5: emit(enc_i6(OP_ST, rd, ra, int'($urandom_range(0, 63))));
            6: emit(enc_i9(OP_BZ, rd, int'($urandom_range(0, 3))));
            7: emit(enc_i9(OP_BNZ, rd, int'($urandom_range(0, 3))));
            default: emit(16'(int'($urandom_range(8, 14)) << 12));
         endcase
      end
      emit_dump();
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ALU
      pl = 0;
      emit(enc_i9(OP_LI, 1, 5));
      emit(enc_i9(OP_LI, 2, -3));
      emit(enc_alu(0, 3, 1, 2));
      emit(enc_alu(1, 4, 1, 2));
      emit(enc_alu(7, 5, 2, 1));
      emit_dump();
      run_prog("alu");
      check("alu:r1", dmem[25], 16'h0005);
      check("alu:r2", dmem[26], 16'hFFFD);
      check("alu:add", dmem[27], 16'h0002);
      check("alu:sub", dmem[28], 16'h0008);
      check("alu:sltu", dmem[29], 16'h0000);

      // Load / store
      pl = 0;
      emit(enc_i9(OP_LI, 1, 16'h40));
      emit(enc_i9(OP_LI, 2, 16'h91));
      emit(enc_i9(OP_LI, 5, 5));
      emit(enc_alu(5, 2, 2, 5));
      emit(enc_i6(OP_ADDI, 2, 2, 20));
      emit(enc_i6(OP_ST, 2, 1, 2));
      emit(enc_i6(OP_LD, 3, 1, 2));
      emit(enc_i6(OP_ADDI, 4, 3, 1));
      emit_dump();
      run_prog("ldst");
      check("ldst:st_kind", 16'(dut_ev(0).is_st), 16'd1);
      check("ldst:waddr", dut_ev(0).addr, 16'h0042);
      check("ldst:wdata", dut_ev(0).data, 16'h1234);
      check("ldst:ld_kind", 16'(dut_ev(1).is_st), 16'd0);
      check("ldst:raddr", dut_ev(1).addr, 16'h0042);
      check("ldst:ld_cyc", 16'(dut_ev(1).cyc), 16'd8);
      check("ldst:bubble_cyc", 16'(dut_ev(2).cyc), 16'd11);
      check("ldst:r4", dmem[28], 16'h1235);

      // Branches
      pl = 0;
      emit(enc_i9(OP_LI, 1, 0));
      emit(enc_i9(OP_BZ, 1, 2));
      emit(enc_i9(OP_LI, 6, 16'h11));
      emit(enc_i9(OP_LI, 6, 16'h22));
      emit(enc_i9(OP_BNZ, 1, 5));
      emit(enc_i9(OP_LI, 2, 7));
      emit_dump();
      run_prog("branch");
      check("branch:first_store_cyc", 16'(dut_ev(0).cyc), 16'd7);
      check("branch:r6_squashed", dmem[30], 16'h0000);
      check("branch:r2", dmem[26], 16'h0007);

      // JAL and r0 writes
      pl = 0;
      emit(enc_i9(OP_LI, 6, 16'h10));
      for (int i = 0; i < 4; i++) emit(16'h8000);
      emit(enc_i6(OP_JAL, 7, 6, 0));
      while (pl < 16) emit(enc_i9(OP_LI, 1, -1));
      emit(enc_i9(OP_LI, 0, 9));
      emit(enc_i6(OP_ST, 0, 0, 24));
      emit_dump();
      run_prog("jal");
      check("jal:target_cyc", 16'(dut_ev(0).cyc), 16'd10);
      check("jal:r0_store_addr", dut_ev(0).addr, 16'h0018);
      check("jal:r0_data", dut_ev(0).data, 16'h0000);
      check("jal:r7_link", dmem[31], 16'h0006);
      check("jal:r1_squashed", dmem[25], 16'h0000);

      // Halt opcode
      pl = 0;
      emit(enc_i9(OP_LI, 1, 1));
      emit(16'h8000);
      emit(16'h8000);
      emit(16'hF000);
      emit(enc_i6(OP_ST, 1, 0, 5));
      emit_dump();
      run_prog("halt");
`ifdef CPU_HALT_EN
      check("halt:halted", {15'b0, halted}, 16'h1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("halt:iaddr_frozen", iaddr, 16'h0004);
         check("halt:re", {15'b0, re}, 16'h0);
         check("halt:we", {15'b0, we}, 16'h0);
      end
`else
      check("halt:halted", {15'b0, halted}, 16'h0);
      check("halt:continue_addr", dut_ev(0).addr, 16'h0005);
      check("halt:continue_cyc", 16'(dut_ev(0).cyc), 16'd6);
`endif

      // Random programs
      for (int p = 0; p < 8; p++) begin
         gen_random(40);
         run_prog($sformatf("rand%0d", p));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_2stage.md
Name: cpu_2stage

Overview:
- 16-bit, two-stage (fetch / execute) in-order CPU core with separate instruction and data memory ports.
- Word-addressed; 16-bit instructions.
- Sits between an instruction memory and a data memory, both with 1-cycle synchronous read.
- Eight 16-bit general registers; r0 reads as zero.

Parameters:
RESET_PC, 16'h0000, fetch address after reset.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
iaddr  out  16  instruction word address (= PC register)
idata  in  16  instruction word; valid one cycle after iaddr
raddr  out  16  data read address
rdata  in  16  read data; valid one cycle after raddr with re=1
re  out  1  data read enable
waddr  out  16  data write address
wdata  out  16  data write value
we  out  1  data write enable; memory writes at the next clk edge
halted  out  1  core halted (tied 0 unless HALT_EN)

Behaviour:
- Reset and startup:
  - Reset (sampled on clk): pc=RESET_PC, exec_valid=0, ld_pending=0, halted=0, all registers=0.
  - iaddr follows pc, so iaddr=RESET_PC during reset.
  - re/we/raddr/waddr/wdata are 0 whenever the execute stage is invalid or in reset.
  - First edge after reset: exec_valid=1, exec_pc=RESET_PC, pc=RESET_PC+1.
  - Reset asserted mid-operation abandons any in-flight load or branch.
- Pipeline:
  - Fetch: iaddr=pc.
  - Execute: decodes idata when exec_valid, tagged with exec_pc.
  - Normal advance: pc<=pc+1, exec_pc<=pc; 16-bit wrap 16'hFFFF->0.
- Encoding: op=[15:12], rd=[11:9], ra=[8:6], rb=[5:3], fn=[2:0]. simm6=sext([5:0]); simm9=sext([8:0]).
- Instructions:
  - 0 ALU: rd=ra fn rb. fn: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl by rb[3:0], 6 logical shr by rb[3:0], 7 unsigned slt (1/0). Arithmetic modulo 2^16.
  - 1 ADDI: rd=ra+simm6.
  - 2 LI: rd=simm9.
  - 3 LD: rd=mem[ra+simm6].
  - 4 ST: mem[ra+simm6]=rd (drives we=1, waddr, wdata=rd combinationally in execute).
  - 5 BZ: if rd==0, pc<=exec_pc+1+simm9.
  - 6 BNZ: if rd!=0, same target.
  - 7 JAL: rd=exec_pc+1; pc<=ra (old ra value when rd==ra).
  - 8-E: NOP.
  - F: HALT (see Optional Feature).
- Writes to r0 are discarded.
- Taken branch or JAL: the in-flight fetched word is squashed (exec_valid<=0 next cycle). 1-cycle penalty.
- Load timing:
  - Execute cycle: re=1, raddr=ra+simm6, pc held, ld_pending<=1, ld_rd latched, exec_valid<=0.
  - Next cycle: rdata is written to ld_rd; the arriving word is discarded; the same pc is refetched.
  - A load followed immediately by a use of its destination needs no interlock.
- Register file: two async reads, one sync write. No write-after-read forwarding is needed; execute writes complete at the edge.
- Store and load are never active in the same cycle.

Optional Feature:
Macro CPU_HALT_EN.
- Defined:
  - Opcode F sets halted=1 and freezes pc. exec_valid<=0 thereafter.
  - re=we=0 until reset.
- Undefined: opcode F is NOP and halted is constant 0.

Decomposition:
- Package cpu_pkg: opcode enum, ALU fn enum, field bit positions, REG_COUNT=8, XLEN=16.
- One sub-module cpu_regfile: 8x16, r0 hardwired 0, ports ra/rb read, rd/we write, clk/rst clear.

Test Plan:
- Reset: hold rst 2 cycles -> iaddr=0000, re=0, we=0. First edge after release -> exec_pc=0000, iaddr=0001.
- ALU: LI r1,5; LI r2,-3; ADD r3,r1,r2; SUB r4,r1,r2; SLT r5,r2,r1 -> r3=0002, r4=0008, r5=0 (FFFD>5 unsigned).
- Load/store: LI r1,0x40; LI r2,0x1234; ST r2,[r1+2]; LD r3,[r1+2]; ADDI r4,r3,1 -> we=1 with waddr=0042, wdata=1234; re=1 with raddr=0042; r4=1235 with one bubble cycle.
- Branches: LI r1,0; BZ r1,+2 -> the instruction at pc+1 is squashed and execution resumes at branch_pc+3. BNZ r1 is not taken and costs no bubble.
- JAL: JAL r7,r6 with r6=0x0010 at pc 0x0005 -> r7=0006, next executed pc=0010. r0 writes remain 0.
- Halt (CPU_HALT_EN): HALT at 0x0003 -> halted=1, iaddr frozen, no we/re pulses for 10 cycles. Without the macro, execution continues at 0x0004.
